// File: rtl/formula_n_sqrt_fsm.sv
// Sum-of-roots / nested-roots formula sequencer sharing one external isqrt unit.
// Define SQRT_FORMULA_OVF_EN to add the ovf output flagging mode-1 addition carries.
module formula_n_sqrt_fsm #(
    parameter int unsigned N_ARGS = 3,
    parameter int unsigned WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arg_vld,
    input  logic                    mode,
    input  logic [N_ARGS*WIDTH-1:0] args,
    output logic                    busy,
    output logic                    res_vld,
    output logic [WIDTH-1:0]        res,
    output logic                    isqrt_x_vld,
    output logic [WIDTH-1:0]        isqrt_x,
    input  logic                    isqrt_y_vld,
    input  logic [WIDTH/2-1:0]      isqrt_y
`ifdef SQRT_FORMULA_OVF_EN
    ,
    output logic                    ovf
`endif
);

    localparam int unsigned IDX_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ARGS - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] args_q [N_ARGS];
    logic             mode_q;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] acc;
    logic [IDX_W-1:0] idx_p1;
    logic [IDX_W-1:0] idx_m1;
    logic [WIDTH-1:0] y_ext;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH:0]   nest_sum;

    always_comb begin
        idx_p1   = idx + 1'b1;
        idx_m1   = idx - 1'b1;
        y_ext    = WIDTH'(isqrt_y);
        acc_sum  = acc + y_ext;
        // Extra bit keeps the carry of the mode-1 addition visible.
        nest_sum = {1'b0, args_q[idx_m1]} + {1'b0, y_ext};
    end

`ifdef SQRT_FORMULA_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`else
    logic unused_carry;
    assign unused_carry = nest_sum[WIDTH];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            busy        <= 1'b0;
            res_vld     <= 1'b0;
            res         <= '0;
            isqrt_x_vld <= 1'b0;
            isqrt_x     <= '0;
            idx         <= '0;
            acc         <= '0;
            mode_q      <= 1'b0;
            for (int i = 0; i < N_ARGS; i++) begin
                args_q[i] <= '0;
            end
`ifdef SQRT_FORMULA_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            res_vld     <= 1'b0;
            isqrt_x_vld <= 1'b0;
            case (state)
                // DONE also accepts a request so back-to-back runs lose no cycle.
                StIdle, StDone: begin
                    state <= StIdle;
                    if (arg_vld) begin
                        for (int i = 0; i < N_ARGS; i++) begin
                            args_q[i] <= args[i*WIDTH +: WIDTH];
                        end
                        mode_q      <= mode;
                        acc         <= '0;
                        busy        <= 1'b1;
                        isqrt_x_vld <= 1'b1;
                        state       <= StIssue;
`ifdef SQRT_FORMULA_OVF_EN
                        ovf_q       <= 1'b0;
`endif
                        if (mode) begin
                            idx     <= LAST;
                            isqrt_x <= args[(N_ARGS-1)*WIDTH +: WIDTH];
                        end else begin
                            idx     <= '0;
                            isqrt_x <= args[WIDTH-1:0];
                        end
                    end
                end
                StIssue: state <= StWait;
                StWait: begin
                    if (isqrt_y_vld) begin
                        if (!mode_q) begin
                            if (idx == LAST) begin
                                res     <= acc_sum;
                                res_vld <= 1'b1;
                                busy    <= 1'b0;
                                state   <= StDone;
                            end else begin
                                acc         <= acc_sum;
                                idx         <= idx_p1;
                                isqrt_x     <= args_q[idx_p1];
                                isqrt_x_vld <= 1'b1;
                                state       <= StIssue;
                            end
                        end else begin
                            if (idx == '0) begin
                                res     <= y_ext;
                                res_vld <= 1'b1;
                                busy    <= 1'b0;
                                state   <= StDone;
                            end else begin
                                idx         <= idx_m1;
                                isqrt_x     <= nest_sum[WIDTH-1:0];
                                isqrt_x_vld <= 1'b1;
                                state       <= StIssue;
`ifdef SQRT_FORMULA_OVF_EN
                                ovf_q       <= ovf_q | nest_sum[WIDTH];
`endif
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_formula_n_sqrt_fsm.sv
// Scoreboard bench for formula_n_sqrt_fsm with a 4-cycle isqrt model (N_ARGS=3, WIDTH=32).
module tb_formula_n_sqrt_fsm;

    localparam int unsigned N = 3;
    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           arg_vld = 1'b0;
    logic           mode = 1'b0;
    logic [N*W-1:0] args = '0;
    logic           busy;
    logic           res_vld;
    logic [W-1:0]   res;
    logic           isqrt_x_vld;
    logic [W-1:0]   isqrt_x;
    logic           isqrt_y_vld;
    logic [W/2-1:0] isqrt_y;
`ifdef SQRT_FORMULA_OVF_EN
    logic           ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] exp_x[$], obs_x[$], exp_r[$], obs_r[$];
    int          exp_xc[$], obs_xc[$], exp_rc[$], obs_rc[$];
    logic        exp_o[$], obs_o[$];

    formula_n_sqrt_fsm #(.N_ARGS(N), .WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .arg_vld     (arg_vld),
        .mode        (mode),
        .args        (args),
        .busy        (busy),
        .res_vld     (res_vld),
        .res         (res),
        .isqrt_x_vld (isqrt_x_vld),
        .isqrt_x     (isqrt_x),
        .isqrt_y_vld (isqrt_y_vld),
        .isqrt_y     (isqrt_y)
`ifdef SQRT_FORMULA_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] f_isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'h1 << b);
            if ((32'(t) * 32'(t)) <= x) r = t;
        end
        return r;
    endfunction

    // isqrt model: response four cycles after the request cycle
    logic [3:0]  pv;
    logic [31:0] px [4];
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[2:0], isqrt_x_vld};
            px[0] <= isqrt_x;
            px[1] <= px[0];
            px[2] <= px[1];
            px[3] <= px[2];
        end
    end
    assign isqrt_y_vld = pv[3];
    assign isqrt_y     = pv[3] ? f_isqrt(px[3]) : 16'h0;

    always @(negedge clk) begin
        if (!rst) begin
            if (isqrt_x_vld) begin
                obs_x.push_back(isqrt_x);
                obs_xc.push_back(cyc);
            end
            if (res_vld) begin
                obs_r.push_back(res);
                obs_rc.push_back(cyc);
`ifdef SQRT_FORMULA_OVF_EN
                obs_o.push_back(ovf);
`endif
            end
        end
    end

    task automatic push_expected(input logic m, input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input int t);
        logic [32:0] s;
        logic        o;
        logic [31:0] r;
        exp_xc.push_back(t + 1);
        exp_xc.push_back(t + 6);
        exp_xc.push_back(t + 11);
        if (!m) begin
            exp_x.push_back(a0);
            exp_x.push_back(a1);
            exp_x.push_back(a2);
            r = 32'(f_isqrt(a0)) + 32'(f_isqrt(a1)) + 32'(f_isqrt(a2));
            o = 1'b0;
        end else begin
            exp_x.push_back(a2);
            s = {1'b0, a1} + 33'(f_isqrt(a2));
            o = s[32];
            exp_x.push_back(s[31:0]);
            s = {1'b0, a0} + 33'(f_isqrt(s[31:0]));
            o = o | s[32];
            exp_x.push_back(s[31:0]);
            r = 32'(f_isqrt(s[31:0]));
        end
        exp_r.push_back(r);
        exp_rc.push_back(t + 16);
        exp_o.push_back(o);
    endtask

    // Called at a falling edge; arg_vld is high for exactly the following cycle.
    task automatic req(input logic m, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input bit track);
        mode    = m;
        args    = {a2, a1, a0};
        arg_vld = 1'b1;
        if (track) push_expected(m, a0, a1, a2, cyc);
        @(negedge clk);
        arg_vld = 1'b0;
    endtask

    task automatic wait_results();
        int k = 0;
        while (obs_r.size() < exp_r.size() && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input string name);
        logic [31:0] ev, ov;
        int          ec, oc;
        n_checks++;
        if (obs_x.size() != exp_x.size()) begin
            n_fail++;
            $display("FAIL %s x_count got %0d want %0d", name, obs_x.size(), exp_x.size());
        end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            ev = exp_x.pop_front(); ov = obs_x.pop_front();
            ec = exp_xc.pop_front(); oc = obs_xc.pop_front();
            n_checks++;
            if (ov !== ev || oc !== ec) begin
                n_fail++;
                $display("FAIL %s isqrt_x got %0h@%0d want %0h@%0d", name, ov, oc, ev, ec);
            end
        end
        n_checks++;
        if (obs_r.size() != exp_r.size()) begin
            n_fail++;
            $display("FAIL %s res_count got %0d want %0d", name, obs_r.size(), exp_r.size());
        end
        while (exp_r.size() > 0 && obs_r.size() > 0) begin
            ev = exp_r.pop_front(); ov = obs_r.pop_front();
            ec = exp_rc.pop_front(); oc = obs_rc.pop_front();
            n_checks++;
            if (ov !== ev || oc !== ec) begin
                n_fail++;
                $display("FAIL %s res got %0d@%0d want %0d@%0d", name, ov, oc, ev, ec);
            end
`ifdef SQRT_FORMULA_OVF_EN
            n_checks++;
            if (obs_o.size() == 0 || obs_o[0] !== exp_o[0]) begin
                n_fail++;
                $display("FAIL %s ovf got %b want %b", name,
                         (obs_o.size() > 0) ? obs_o[0] : 1'bx, exp_o[0]);
            end
            if (obs_o.size() > 0) void'(obs_o.pop_front());
`endif
            void'(exp_o.pop_front());
        end
        exp_x.delete(); obs_x.delete(); exp_xc.delete(); obs_xc.delete();
        exp_r.delete(); obs_r.delete(); exp_rc.delete(); obs_rc.delete();
        exp_o.delete(); obs_o.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
        if (res_vld !== 1'b0) begin n_fail++; $display("FAIL reset res_vld got %b want 0", res_vld); end
        if (res !== '0) begin n_fail++; $display("FAIL reset res got %0h want 0", res); end
        if (isqrt_x_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset isqrt_x_vld got %b want 0", isqrt_x_vld);
        end
        if (isqrt_x !== '0) begin n_fail++; $display("FAIL reset isqrt_x got %0h want 0", isqrt_x); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode0();
        req(1'b0, 32'd16, 32'd9, 32'd4, 1'b1);
        wait_results();
        drain("mode0");
        req(1'b0, 32'd1000000, 32'd99, 32'd65536, 1'b1);
        wait_results();
        drain("mode0_b");
    endtask

    task automatic test_mode1();
        req(1'b1, 32'd2, 32'd7, 32'd4, 1'b1);
        wait_results();
        drain("mode1");
        req(1'b1, 32'd12, 32'd30, 32'd36, 1'b1);
        wait_results();
        drain("mode1_b");
    endtask

    task automatic test_ignore_busy();
        req(1'b0, 32'd1, 32'd1, 32'd1, 1'b1);
        // now at the falling edge of T+1
        for (int k = 1; k <= 16; k++) begin
            n_checks++;
            if (busy !== (k <= 15)) begin
                n_fail++;
                $display("FAIL busy at T+%0d got %b want %b", k, busy, (k <= 15));
            end
            if (k == 3) begin
                args    = {32'd100, 32'd100, 32'd100};
                arg_vld = 1'b1;
            end else begin
                arg_vld = 1'b0;
            end
            @(negedge clk);
        end
        wait_results();
        drain("ignore");
    endtask

    task automatic test_mid_reset();
        req(1'b0, 32'd5, 32'd6, 32'd7, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy got %b want 0", busy); end
        if (res_vld !== 1'b0) begin
            n_fail++; $display("FAIL midrst res_vld got %b want 0", res_vld);
        end
        if (res !== '0) begin n_fail++; $display("FAIL midrst res got %0h want 0", res); end
        if (isqrt_x_vld !== 1'b0) begin
            n_fail++; $display("FAIL midrst isqrt_x_vld got %b want 0", isqrt_x_vld);
        end
        if (isqrt_x !== '0) begin n_fail++; $display("FAIL midrst isqrt_x got %0h want 0", isqrt_x); end
        n_checks++;
        if (obs_x.size() != 2 || obs_x[0] !== 32'd5 || obs_x[1] !== 32'd6) begin
            n_fail++;
            $display("FAIL midrst pre_x got %0d entries want 2 (5,6)", obs_x.size());
        end
        obs_x.delete(); obs_xc.delete(); obs_r.delete(); obs_rc.delete(); obs_o.delete();
        req(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        wait_results();
        drain("after_rst");
    endtask

    task automatic test_back_to_back();
        int k = 0;
        req(1'b0, 32'd16, 32'd9, 32'd4, 1'b1);
        do begin
            @(negedge clk);
            k++;
        end while (!res_vld && k < 40);
        n_checks++;
        if (!res_vld) begin
            n_fail++;
            $display("FAIL b2b res_vld got 0 want 1 within 40 cycles");
        end
        req(1'b1, 32'd2, 32'd7, 32'd4, 1'b1);
        wait_results();
        drain("b2b");
    endtask

    task automatic test_overflow();
        req(1'b1, 32'hFFFF_FFFF, 32'd0, 32'd4, 1'b1);
        wait_results();
        drain("ovf_mode1");
        req(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_results();
        drain("ovf_mode0");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_ignore_busy();
        test_mid_reset();
        test_back_to_back();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/formula_n_sqrt_fsm.md
Name: formula_n_sqrt_fsm

Overview:
- Generalised square-root formula FSM with N_ARGS arguments and a runtime mode select.
- Two modes:
  - Mode 0 (sum): res = sqrt(a0) + sqrt(a1) + ... + sqrt(a[N-1]).
  - Mode 1 (nested): res = sqrt(a0 + sqrt(a1 + ... + sqrt(a[N-1]))).
- Shares one external isqrt unit, driven through a request/response port pair, so the same block serves any isqrt implementation and latency.
- Sits between the formula benches and the isqrt cores, replacing the fixed 3-argument formula FSMs.

Parameters:
- N_ARGS, 3, number of arguments; must be >= 1.
- WIDTH, 32, argument and result width in bits; must be even.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- arg_vld  input  1  request strobe; args and mode are sampled on it.
- mode  input  1  0 = sum of roots, 1 = nested roots.
- args  input  N_ARGS*WIDTH  packed arguments; a0 occupies bits [WIDTH-1:0].
- busy  output  1  high while a computation is in flight.
- res_vld  output  1  one-cycle result strobe.
- res  output  WIDTH  result, valid only while res_vld is high.
- isqrt_x_vld  output  1  one-cycle isqrt request strobe.
- isqrt_x  output  WIDTH  isqrt operand.
- isqrt_y_vld  input  1  isqrt response strobe.
- isqrt_y  input  WIDTH/2  isqrt result, floor(sqrt(x)).

Behaviour:
- Reset values: busy=0, res_vld=0, res=0, isqrt_x_vld=0, isqrt_x=0; state=IDLE.
- States and transitions:
  - IDLE: on arg_vld, latch args and mode, clear the accumulator, set the index (0 in mode 0, N_ARGS-1 in mode 1), go to ISSUE.
  - ISSUE: assert isqrt_x_vld for exactly one cycle, then go to WAIT. Operand: mode 0 drives a[idx]; mode 1 drives a[N-1] on the first step and a[idx]+prev_y afterwards.
  - WAIT: hold until isqrt_y_vld.
    - Mode 0: acc += isqrt_y. If idx==N_ARGS-1 go to DONE, else idx++ and go to ISSUE.
    - Mode 1: if idx==0, res=isqrt_y (zero-extended) and go to DONE; else precompute a[idx-1]+isqrt_y truncated to WIDTH bits, idx--, go to ISSUE.
  - DONE: res_vld=1 for one cycle with res valid, then go to IDLE.
- busy is high in ISSUE and WAIT, low in IDLE and DONE.
- New-request acceptance: arg_vld is accepted in IDLE and in DONE (back-to-back). If accepted in DONE, res_vld is still emitted that cycle and the next state is ISSUE.
- arg_vld in ISSUE or WAIT is ignored. Latched args and mode are never altered mid-operation.
- Latency: let arg_vld be high in cycle T and the isqrt latency be L >= 1 (request cycle to response cycle). Then:
  - the first isqrt_x_vld is in cycle T+1;
  - res_vld is in cycle T + N_ARGS*(L+1) + 1.
- Width rules:
  - Mode 0: the sum is held on WIDTH bits and cannot overflow, because N_ARGS*(2^(WIDTH/2)-1) < 2^WIDTH for N_ARGS <= 2^(WIDTH/2)+1.
  - Mode 1: each addition wraps modulo 2^WIDTH.
- isqrt_y_vld outside WAIT is ignored.
- Reset mid-operation returns to IDLE with all outputs at reset values. The isqrt unit is reset by the same rst.
- Only one isqrt request is outstanding at any time.

Optional Feature:
- Macro: SQRT_FORMULA_OVF_EN.
- Defined: adds output port "ovf  output  1".
  - ovf is valid with res_vld and is high if any mode-1 addition carried out of WIDTH bits.
  - ovf is always 0 in mode 0; its reset value is 0.
- Undefined: port absent; mode-1 additions wrap silently; no other behavioural change.

Test Plan:
(N_ARGS=3, WIDTH=32, bench isqrt model with L=4, so latency is 16 cycles after the arg_vld cycle T.)
- Mode 0, args (16,9,4), arg_vld at T -> exactly three isqrt_x_vld pulses with x=16,9,4; res_vld only in cycle T+16; res=9.
- Mode 1, args a0=2, a1=7, a2=4 -> isqrt_x sequence 4, 9, 5; res=2 in cycle T+16.
- Second arg_vld with args (100,100,100) during WAIT of a mode-0 (1,1,1) run -> ignored; single res_vld with res=3; busy high from T+1 through T+15.
- rst pulsed during the second WAIT -> next cycle all outputs 0 and state IDLE; a new mode-0 (0,0,0) request gives res=0 after 16 cycles.
- arg_vld asserted in the res_vld cycle of a prior run -> accepted; the next isqrt_x_vld follows one cycle later; both results correct.
- With SQRT_FORMULA_OVF_EN: mode 1, a0=0xFFFFFFFF, a1=0, a2=4 -> res=0, ovf=1.
  - Chain: sqrt(4)=2; 0+2=2 gives sqrt 1; 0xFFFFFFFF+1 wraps to 0 gives sqrt 0.
  - Mode 0 with all args 0xFFFFFFFF -> res=196605, ovf=0.
